pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer for the sequential core. It sits directly upstream of new_pc.
- Holds the architectural PC, which is driven into new_pc and instruction memory.
- Fetches one instruction per PC through a valid/ready request and valid response interface.
- Presents the instruction to decode, then commits new_PC from new_pc when decode releases.
- Detects halt and misaligned-target conditions.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset.
HALT_INSTR, 32'h0000_0000, instruction encoding that stops fetching.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
new_PC  input  64  next PC computed by new_pc (PC+4 or PC+(imm<<1)).
stall  input  1  decode/execute not ready; hold current instruction and PC.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  instruction memory accepts request.
imem_req_addr  output  64  fetch address; always equals PC.
imem_rsp_valid  input  1  response data valid.
imem_rsp_data  input  32  fetched instruction word.
PC  output  64  current program counter.
instr  output  32  latched instruction.
instr_valid  output  1  instr is valid for decode.
halted  output  1  sticky halt flag.
misaligned  output  1  sticky flag: halt caused by new_PC[1:0] != 0.
retired_count  output  32  count of instructions committed.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted and immediately after release:
  - PC=RESET_PC, instr=0, instr_valid=0, halted=0, misaligned=0, retired_count=0.
  - State=START; imem_req_valid=0.
- All outputs are registered or decoded from the state register. imem_req_addr=PC combinationally.
- START: unconditionally goes to FETCH on the next edge. imem_req_valid is therefore first high in the 2nd cycle after reset release.
- FETCH: imem_req_valid=1.
  - If imem_req_ready=1 on the edge, request is accepted; go to WAIT.
  - Otherwise stay in FETCH. PC must not change while the request is pending.
- WAIT: imem_req_valid=0.
  - If imem_rsp_valid=1, latch imem_rsp_data into instr.
    - If the data equals HALT_INSTR, go to HALTED (instr_valid stays 0).
    - Otherwise set instr_valid=1 and go to ISSUE.
  - A response arriving in any state other than WAIT is ignored.
- ISSUE: instr_valid=1.
  - stall=1: hold PC, instr and state.
  - stall=0, new_PC[1:0]!=0: set misaligned=1 and halted=1; PC unchanged; instr_valid cleared; go to HALTED.
  - stall=0, new_PC aligned: PC<=new_PC, retired_count+=1 (wraps at 2^32), instr_valid<=0, go to FETCH.
- HALTED: terminal until reset.
  - imem_req_valid=0, instr_valid=0, halted=1.
  - PC frozen.
  - A HALT_INSTR halt leaves misaligned=0.
- Latency:
  - Best case is 3 cycles per instruction (FETCH→WAIT→ISSUE) with ready and response each arriving in 1 cycle and no stall.
  - Minimum cycles from request acceptance to instr_valid is 1.
- new_PC is sampled only on the committing edge (ISSUE and stall=0). new_pc must present a stable value during ISSUE.
- Reset mid-operation (any state) aborts the outstanding request. Any later stale response is ignored because the state is not WAIT.
- Simultaneous imem_req_ready and imem_rsp_valid in FETCH: accept the request, ignore the response.
- PC addition wrap: new_PC is taken verbatim; no overflow checking.

Test Plan:
- Reset release, ready=1, rsp in 1 cycle with 32'h00500093, stall=0, new_PC=4 -> req_valid high in cycle 2 with addr 0; instr_valid high in cycle 4; PC=4 next edge; retired_count=1.
- Hold imem_req_ready=0 for 3 cycles in FETCH with PC=8 -> req_valid stays 1, addr stays 8, no state advance; advances to WAIT on the 4th edge once ready=1.
- In ISSUE assert stall for 4 cycles with new_PC=40 -> PC stays 8, instr and instr_valid stable; PC=40 on the edge after stall drops.
- Branch target new_PC=32 from PC=40 -> PC=32, next request addr 32; then new_PC=30 (misaligned) -> misaligned=1, halted=1, PC stays 32, req_valid=0 forever.
- Response 32'h0000_0000 -> halted=1, misaligned=0, instr_valid never asserts, retired_count unchanged.
- Assert reset during WAIT, then deliver imem_rsp_valid one cycle after release -> response ignored, PC=RESET_PC, instr=0, FSM restarts through START/FETCH.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register and one-instruction-at-a-time
// fetch sequencer. Requests the word at PC, holds it for decode, then commits
// the next PC supplied by new_pc. Stops on the halt encoding or on a
// misaligned next-PC.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] new_PC,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [63:0] PC,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] retired_count_q, retired_count_d;
  logic        req_valid_q, req_valid_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halted_q, halted_d;

  // Next-state and datapath update for the fetch sequencer.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    misaligned_d    = misaligned_q;
    retired_count_d = retired_count_q;
    case (state_q)
      S_START: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // A response seen here is stale or unsolicited and is dropped.
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = (imem_rsp_data == HALT_INSTR) ? S_HALTED : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          if (new_PC[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
            state_d      = S_HALTED;
          end else begin
            pc_d            = new_PC;
            retired_count_d = retired_count_q + 32'd1;
            state_d         = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_START;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_comb begin
    req_valid_d   = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_ISSUE);
    halted_d      = (state_d == S_HALTED);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_START;
      pc_q            <= RESET_PC;
      instr_q         <= '0;
      misaligned_q    <= 1'b0;
      retired_count_q <= '0;
      req_valid_q     <= 1'b0;
      instr_valid_q   <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      misaligned_q    <= misaligned_d;
      retired_count_q <= retired_count_d;
      req_valid_q     <= req_valid_d;
      instr_valid_q   <= instr_valid_d;
      halted_q        <= halted_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign PC             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign halted         = halted_q;
  assign misaligned     = misaligned_q;
  assign retired_count  = retired_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: walks the fetch/issue/commit sequence,
// back-pressure, stalls, branch/misaligned halt, halt instruction and
// reset-abort with a stale response.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] new_PC;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [63:0] PC;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        misaligned;
  logic [31:0] retired_count;

  int unsigned total;
  int unsigned bad;

  pc_fetch_unit #(
    .RESET_PC  (64'd0),
    .HALT_INSTR(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .new_PC        (new_PC),
    .stall         (stall),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .PC            (PC),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .misaligned    (misaligned),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before checking/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    new_PC = 64'd0;
    stall = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    tick();
    tick();
    // Reset state
    chk("rst_pc", PC, 64'd0);
    chk("rst_instr", instr, 64'd0);
    chk("rst_ivalid", instr_valid, 64'd0);
    chk("rst_halted", halted, 64'd0);
    chk("rst_mis", misaligned, 64'd0);
    chk("rst_rc", retired_count, 64'd0);
    chk("rst_reqv", imem_req_valid, 64'd0);

    // Release: cycle 1 is START
    reset = 1'b0;
    chk("start_reqv", imem_req_valid, 64'd0);
    imem_req_ready = 1'b1;
    tick();
    chk("c2_reqv", imem_req_valid, 64'd1);
    chk("c2_addr", imem_req_addr, 64'd0);
    tick();
    chk("wait_reqv", imem_req_valid, 64'd0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    tick();
    chk("c4_ivalid", instr_valid, 64'd1);
    chk("c4_instr", instr, 64'h0050_0093);
    imem_rsp_valid = 1'b0;
    new_PC = 64'd4;
    tick();
    chk("commit1_pc", PC, 64'd4);
    chk("commit1_rc", retired_count, 64'd1);
    chk("commit1_ivalid", instr_valid, 64'd0);
    chk("commit1_reqv", imem_req_valid, 64'd1);

    // Second instruction to reach PC=8
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    new_PC = 64'd8;
    tick();
    chk("commit2_pc", PC, 64'd8);
    chk("commit2_rc", retired_count, 64'd2);

    // Back-pressure: ready low 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_reqv", imem_req_valid, 64'd1);
      chk("bp_addr", imem_req_addr, 64'd8);
      chk("bp_ivalid", instr_valid, 64'd0);
    end
    // Accept with a simultaneous response, which must be ignored
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick();
    chk("acc_reqv", imem_req_valid, 64'd0);
    chk("acc_instr_kept", instr, 64'h0000_0013);
    chk("acc_ivalid", instr_valid, 64'd0);
    imem_req_ready = 1'b0;
    imem_rsp_data  = 32'h0010_8113;
    tick();
    chk("iss3_ivalid", instr_valid, 64'd1);
    chk("iss3_instr", instr, 64'h0010_8113);
    imem_rsp_valid = 1'b0;

    // Stall 4 cycles in ISSUE
    stall  = 1'b1;
    new_PC = 64'd40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pc", PC, 64'd8);
      chk("stall_instr", instr, 64'h0010_8113);
      chk("stall_ivalid", instr_valid, 64'd1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc", PC, 64'd40);
    chk("unstall_rc", retired_count, 64'd3);

    // Branch to 32
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    new_PC = 64'd32;
    tick();
    chk("br_pc", PC, 64'd32);
    chk("br_addr", imem_req_addr, 64'd32);
    chk("br_reqv", imem_req_valid, 64'd1);
    chk("br_rc", retired_count, 64'd4);

    // Misaligned target 30
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    new_PC = 64'd30;
    tick();
    chk("mis_halted", halted, 64'd1);
    chk("mis_flag", misaligned, 64'd1);
    chk("mis_pc", PC, 64'd32);
    chk("mis_ivalid", instr_valid, 64'd0);
    chk("mis_rc", retired_count, 64'd4);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    new_PC = 64'd64;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_reqv", imem_req_valid, 64'd0);
      chk("hold_pc", PC, 64'd32);
      chk("hold_halted", halted, 64'd1);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;

    // Halt instruction
    reset = 1'b1;
    #1;
    chk("rst2_mis", misaligned, 64'd0);
    chk("rst2_pc", PC, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0000;
    tick();
    imem_rsp_valid = 1'b0;
    chk("hi_halted", halted, 64'd1);
    chk("hi_mis", misaligned, 64'd0);
    chk("hi_ivalid", instr_valid, 64'd0);
    chk("hi_rc", retired_count, 64'd0);
    tick();
    chk("hi_ivalid2", instr_valid, 64'd0);
    chk("hi_reqv2", imem_req_valid, 64'd0);

    // Reset during WAIT, stale response after release
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("w_reqv", imem_req_valid, 64'd0);
    reset = 1'b1;
    #1;
    chk("wrst_pc", PC, 64'd0);
    chk("wrst_reqv", imem_req_valid, 64'd0);
    tick();
    reset = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEC;
    tick();
    chk("stale_instr", instr, 64'd0);
    chk("stale_ivalid", instr_valid, 64'd0);
    chk("stale_reqv", imem_req_valid, 64'd1);
    chk("stale_pc", PC, 64'd0);
    tick();
    chk("stale2_instr", instr, 64'd0);
    chk("stale2_reqv", imem_req_valid, 64'd1);
    imem_rsp_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
